// File: rtl/gated_bus_reg.sv
// Registered N-source bus select with lowest-index priority, bus-keeper/idle
// drive, and sticky multi-gate conflict detection with a saturating counter.
module gated_bus_reg #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      N        = 4,
    parameter int unsigned      CNT_W    = 8,
    parameter bit               KEEP     = 1'b1,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N*WIDTH-1:0]   src_data,
    input  logic [N-1:0]         gate,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bus_out,
    output logic                 bus_valid,
    output logic [$clog2(N)-1:0] bus_src,
    output logic                 conflict,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int unsigned SW = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] bus_q, bus_d;
    logic             valid_q, valid_d;
    logic [SW-1:0]    src_q, src_d;
    logic             conf_q, conf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    sel_idx;
    logic             any_gate;
    logic             multi_gate;

    // Walk from the top down so the lowest set index is the last to assign;
    // only a gated lane is ever read, keeping ungated X off the bus.
    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (gate[i]) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
                sel_idx  = SW'(i);
            end
        end
        any_gate   = |gate;
        multi_gate = |(gate & (gate - N'(1)));
    end

    always_comb begin
        bus_d   = bus_q;
        valid_d = 1'b0;
        src_d   = src_q;
        conf_d  = conf_q;
        cnt_d   = cnt_q;

        if (any_gate) begin
            bus_d   = sel_data;
            src_d   = sel_idx;
            valid_d = 1'b1;
        end else if (!KEEP) begin
            bus_d = IDLE_VAL;
        end

        // A conflict in the same cycle as a clear counts as the first new one.
        if (multi_gate) begin
            conf_d = 1'b1;
            if (clr_err)
                cnt_d = CNT_W'(1);
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_W'(1);
        end else if (clr_err) begin
            conf_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus_q   <= IDLE_VAL;
            valid_q <= 1'b0;
            src_q   <= '0;
            conf_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
            src_q   <= src_d;
            conf_q  <= conf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_out      = bus_q;
    assign bus_valid    = valid_q;
    assign bus_src      = src_q;
    assign conflict     = conf_q;
    assign conflict_cnt = cnt_q;

endmodule
